regfile_wb_arbiter: RTL and testbench

- Controls the single write port of the 32x32 register file.
- Arbitrates between two writeback requesters: the execute unit (ALU results) and the memory unit (load results).
- Registers the winning request onto the write port.
- Keeps a per-register pending scoreboard so the decode stage can detect read-after-write hazards.

---
 rtl/regfile_wb_arbiter_pkg.sv | 31 +++
 rtl/regfile_wb_arbiter_scoreboard.sv | 39 +++
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU definitions used by the writeback arbiter and its scoreboard.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] rd_onehot(
        input logic [REG_ADDR_W-1:0] rd
    );
        logic [NUM_REGS-1:0] oh;
        oh     = '0;
        oh[rd] = 1'b1;
        return oh;
    endfunction

    function automatic logic req_is_x0(input wb_req_t r);
        return r.valid && (r.rd == '0);
    endfunction

    function automatic logic req_writes(input wb_req_t r);
        return r.valid && (r.rd != '0);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Per-register pending-write bits used by decode for RAW hazard detection.
module regfile_wb_arbiter_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set_en_i,
    input  logic [REG_ADDR_W-1:0] set_rd_i,
    input  logic                  clr_en_i,
    input  logic [REG_ADDR_W-1:0] clr_rd_i,
    output logic [NUM_REGS-1:0]   pending_mask_o
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    // Set is applied after clear so a newly issued writer keeps its bit.
    always_comb begin
        pend_d = pend_q;
        if (clr_en_i) begin
            pend_d = pend_d & ~rd_onehot(clr_rd_i);
        end
        if (set_en_i && (set_rd_i != '0)) begin
            pend_d = pend_d | rd_onehot(set_rd_i);
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pending_mask_o = pend_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter driving the single register-file write port,
// with starvation protection for the execute unit and a pending scoreboard.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_data,
    output logic        ex_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [31:0] pending_mask
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    wb_req_t ex_req;
    wb_req_t mem_req;

    assign ex_req  = '{valid: ex_valid,  rd: ex_rd,  data: ex_data};
    assign mem_req = '{valid: mem_valid, rd: mem_rd, data: mem_data};

    logic ex_wr;
    logic mem_wr;
    logic ex_x0;
    logic mem_x0;
    logic starved;
    logic grant_ex;
    logic grant_mem;
    logic grant_any;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic                  wb_we_q;
    logic                  wb_we_d;
    logic [REG_ADDR_W-1:0] wb_addr_q;
    logic [REG_ADDR_W-1:0] wb_addr_d;
    logic [XLEN-1:0]       wb_data_q;
    logic [XLEN-1:0]       wb_data_d;

    assign ex_wr   = req_writes(ex_req);
    assign mem_wr  = req_writes(mem_req);
    assign ex_x0   = req_is_x0(ex_req);
    assign mem_x0  = req_is_x0(mem_req);
    assign starved = (cnt_q == LIMIT);

    // Memory has priority except when execute has lost too many times.
    assign grant_ex  = ex_wr && (!mem_wr || starved);
    assign grant_mem = mem_wr && !grant_ex;
    assign grant_any = grant_ex || grant_mem;

    assign ex_ready  = !reset && (ex_x0 || grant_ex);
    assign mem_ready = !reset && (mem_x0 || grant_mem);

    always_comb begin
        cnt_d = '0;
        if (ex_wr && !grant_ex) begin
            cnt_d = starved ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_comb begin
        wb_we_d   = grant_any;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (grant_ex) begin
            wb_addr_d = ex_req.rd;
            wb_data_d = ex_req.data;
        end else if (grant_mem) begin
            wb_addr_d = mem_req.rd;
            wb_data_d = mem_req.data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_we   = wb_we_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;

    // Clear lands on the same edge that registers the write.
    regfile_wb_arbiter_scoreboard u_scoreboard (
        .clock          (clock),
        .reset          (reset),
        .set_en_i       (issue_valid),
        .set_rd_i       (issue_rd),
        .clr_en_i       (grant_any),
        .clr_rd_i       (wb_addr_d),
        .pending_mask_o (pending_mask)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed vectors plus a held-request stress phase.
module tb_regfile_wb_arbiter;

    localparam int LIM = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ex_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] pending_mask;

    int n_cmp = 0;
    int n_bad = 0;

    logic [36:0] exp_q[$];

    always #5 clock = ~clock;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_rd        (ex_rd),
        .ex_data      (ex_data),
        .ex_ready     (ex_ready),
        .mem_valid    (mem_valid),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .pending_mask (pending_mask)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic iv, input logic [4:0] ird);
        ex_valid    = ev;
        ex_rd       = erd;
        ex_data     = ed;
        mem_valid   = mv;
        mem_rd      = mrd;
        mem_data    = md;
        issue_valid = iv;
        issue_rd    = ird;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every port write must match the oldest expected write.
    always @(negedge clock) begin
        if (wb_we === 1'b1) begin
            logic [36:0] e;
            chk("wb_addr_nonzero", 32'(wb_addr != 5'd0), 1);
            chk("wb_expected_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wb_addr", 32'(wb_addr), 32'(e[36:32]));
                chk("wb_data", wb_data, e[31:0]);
            end
        end
    end

    logic        rev, rmv, riv;
    logic [4:0]  rerd, rmrd, rird;
    logic [31:0] red, rmd;
    logic [31:0] m_mask;
    int          m_cnt;
    int          ex_wait;

    function automatic logic [4:0] rnd_rd();
        return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    endfunction

    initial begin
        reset = 1'b1;
        drive(1, 5, 32'h11, 1, 6, 32'h22, 1, 4);
        #1;
        chk("rst_ex_ready", 32'(ex_ready), 0);
        chk("rst_mem_ready", 32'(mem_ready), 0);
        tick();
        chk("rst_wb_we", 32'(wb_we), 0);
        chk("rst_wb_addr", 32'(wb_addr), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_mask", pending_mask, 0);
        idle();
        tick();
        reset = 1'b0;
        tick();

        // single ex request
        drive(1, 5, 32'h1234, 0, 0, 0, 0, 0);
        #1;
        chk("single_ex_ready", 32'(ex_ready), 1);
        chk("single_mem_ready", 32'(mem_ready), 0);
        exp_q.push_back({5'd5, 32'h1234});
        tick();
        chk("single_wb_we", 32'(wb_we), 1);
        chk("single_wb_addr", 32'(wb_addr), 5);
        idle();
        tick();
        chk("single_we_drop", 32'(wb_we), 0);
        chk("single_addr_hold", 32'(wb_addr), 5);

        // conflict: mem wins three times, then ex
        for (int k = 0; k < LIM; k++) begin
            drive(1, 3, 32'hA3, 1, 4, 32'h400 + k, 0, 0);
            #1;
            chk("conf_ex_ready_lose", 32'(ex_ready), 0);
            chk("conf_mem_ready_win", 32'(mem_ready), 1);
            exp_q.push_back({5'd4, 32'h400 + k});
            tick();
        end
        drive(1, 3, 32'hA3, 1, 4, 32'h4FF, 0, 0);
        #1;
        chk("conf_ex_ready_starved", 32'(ex_ready), 1);
        chk("conf_mem_ready_starved", 32'(mem_ready), 0);
        exp_q.push_back({5'd3, 32'hA3});
        tick();
        chk("conf_wb_addr_ex", 32'(wb_addr), 3);
        drive(1, 3, 32'hB3, 1, 4, 32'h4FF, 0, 0);
        #1;
        chk("conf_cnt_clear_ex", 32'(ex_ready), 0);
        chk("conf_cnt_clear_mem", 32'(mem_ready), 1);
        exp_q.push_back({5'd4, 32'h4FF});
        tick();
        idle();
        tick();

        // x0 bypass
        drive(1, 0, 32'hDEAD, 1, 7, 32'h77, 0, 0);
        #1;
        chk("x0_ex_ready", 32'(ex_ready), 1);
        chk("x0_mem_ready", 32'(mem_ready), 1);
        exp_q.push_back({5'd7, 32'h77});
        tick();
        chk("x0_mask", pending_mask, 0);
        idle();
        tick();
        tick();

        // scoreboard
        drive(0, 0, 0, 0, 0, 0, 1, 9);
        tick();
        chk("sb_set9", pending_mask, 32'h200);
        drive(0, 0, 0, 1, 9, 32'h99, 0, 0);
        #1;
        chk("sb_mem_ready", 32'(mem_ready), 1);
        exp_q.push_back({5'd9, 32'h99});
        tick();
        chk("sb_clr9_we", 32'(wb_we), 1);
        chk("sb_clr9", pending_mask, 0);
        drive(0, 0, 0, 1, 9, 32'h999, 1, 9);
        exp_q.push_back({5'd9, 32'h999});
        tick();
        chk("sb_set_wins", pending_mask, 32'h200);
        drive(1, 9, 32'h9E, 0, 0, 0, 1, 10);
        exp_q.push_back({5'd9, 32'h9E});
        tick();
        chk("sb_set_clr_diff", pending_mask, 32'h400);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        chk("sb_issue_x0", pending_mask, 32'h400);

        // reset with a registered write in flight
        drive(1, 5, 32'h55, 0, 0, 0, 1, 9);
        exp_q.push_back({5'd5, 32'h55});
        tick();
        chk("mrst_pre_we", 32'(wb_we), 1);
        chk("mrst_pre_mask", pending_mask, 32'h600);
        reset = 1'b1;
        drive(1, 6, 32'h66, 1, 8, 32'h88, 0, 0);
        #1;
        chk("mrst_ex_ready", 32'(ex_ready), 0);
        chk("mrst_mem_ready", 32'(mem_ready), 0);
        tick();
        chk("mrst_wb_we", 32'(wb_we), 0);
        chk("mrst_mask", pending_mask, 0);
        idle();
        reset = 1'b0;
        tick();

        // stress: requesters hold until accepted
        rev = 0; rmv = 0; riv = 0;
        rerd = 0; rmrd = 0; rird = 0; red = 0; rmd = 0;
        m_mask = 0;
        m_cnt = 0;
        ex_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            logic exw, memw, gex, gmem, er, mr;
            if (!rev && $urandom_range(0, 9) < 6) begin
                rev = 1; rerd = rnd_rd(); red = $urandom();
            end
            if (!rmv && $urandom_range(0, 9) < 7) begin
                rmv = 1; rmrd = rnd_rd(); rmd = $urandom();
            end
            riv  = ($urandom_range(0, 3) == 0);
            rird = rnd_rd();
            drive(rev, rerd, red, rmv, rmrd, rmd, riv, rird);
            #1;
            exw  = rev && rerd != 0;
            memw = rmv && rmrd != 0;
            gex  = exw && (!memw || m_cnt == LIM);
            gmem = memw && !gex;
            er   = (rev && rerd == 0) || gex;
            mr   = (rmv && rmrd == 0) || gmem;
            if (rev) chk("rnd_ex_ready", 32'(ex_ready), 32'(er));
            if (rmv) chk("rnd_mem_ready", 32'(mem_ready), 32'(mr));
            if (gex) exp_q.push_back({rerd, red});
            if (gmem) exp_q.push_back({rmrd, rmd});
            if (exw) begin
                ex_wait++;
                if (gex) begin
                    chk("rnd_ex_wait_bound", 32'(ex_wait <= LIM + 1), 1);
                    ex_wait = 0;
                end
            end
            if (exw && !gex) m_cnt = (m_cnt == LIM) ? LIM : m_cnt + 1;
            else m_cnt = 0;
            if (gex) m_mask[rerd] = 1'b0;
            if (gmem) m_mask[rmrd] = 1'b0;
            if (riv && rird != 0) m_mask[rird] = 1'b1;
            if (er) rev = 0;
            if (mr) rmv = 0;
            tick();
            chk("rnd_mask", pending_mask, m_mask);
        end
        idle();
        tick();
        tick();
        tick();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
